// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
//
// Two requesters share one external combinational ALU. Only one operation is
// in flight at a time: IDLE -> EXEC -> RESP -> IDLE.
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   req{0,1}_valid/ready     request handshake (ready is combinational, IDLE only)
//   req{0,1}_a/_b/_ctrl      request operands and ALUControl code
//   rsp{0,1}_valid/ready     response handshake, valid only for the owner
//   rsp_result, rsp_z/n/v/c  registered ALU result and flags
//   rsp_err                  ctrl was an unsupported code (100, 110, 111)
//   alu_a/_b/_ctrl           registered operands to the ALU instance
//   alu_result, alu_z/n/v/c  ALU outputs
//   op_cnt                   completed responses, wraps
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_ctrl,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_z,
  output logic             rsp_n,
  output logic             rsp_v,
  output logic             rsp_c,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_v,
  input  logic             alu_c,
  output logic [CNT_W-1:0] op_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   owner;
  logic   last_grant;
  logic   grant0;
  logic   grant1;
  logic   rsp_hs;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // rsp valids are only ever high in RESP, so this is the owner's handshake.
  assign rsp_hs = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= 3'b000;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_result <= '0;
      rsp_z      <= 1'b0;
      rsp_n      <= 1'b0;
      rsp_v      <= 1'b0;
      rsp_c      <= 1'b0;
      rsp_err    <= 1'b0;
      op_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            alu_a      <= grant1 ? req1_a : req0_a;
            alu_b      <= grant1 ? req1_b : req0_b;
            alu_ctrl   <= grant1 ? req1_ctrl : req0_ctrl;
            owner      <= grant1;
            last_grant <= grant1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          // Unsupported codes still go through the ALU; only flagged here.
          rsp_result <= alu_result;
          rsp_z      <= alu_z;
          rsp_n      <= alu_n;
          rsp_v      <= alu_v;
          rsp_c      <= alu_c;
          rsp_err    <= (alu_ctrl == 3'b100) || (alu_ctrl == 3'b110) ||
                        (alu_ctrl == 3'b111);
          rsp0_valid <= !owner;
          rsp1_valid <= owner;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            op_cnt     <= op_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [2:0]    req0_ctrl, req1_ctrl;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0]  rsp_result;
  logic          rsp_z, rsp_n, rsp_v, rsp_c, rsp_err;
  logic [W-1:0]  alu_a, alu_b, alu_result;
  logic [2:0]    alu_ctrl;
  logic          alu_z, alu_n, alu_v, alu_c;
  logic [CW-1:0] op_cnt;

  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic        n;
    logic        v;
    logic        c;
  } alu_out_t;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_z(rsp_z), .rsp_n(rsp_n), .rsp_v(rsp_v),
    .rsp_c(rsp_c), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
    .alu_c(alu_c), .op_cnt(op_cnt)
  );

  // Reference ALU: also serves as the ALU instance the arbiter drives.
  function automatic alu_out_t alu_ref(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] ctrl);
    alu_out_t    o;
    logic [32:0] s;
    o = '0;
    s = '0;
    case (ctrl)
      3'b000: begin
        s   = {1'b0, a} + {1'b0, b};
        o.r = s[31:0];
        o.c = s[32];
        o.v = (a[31] == b[31]) && (o.r[31] != a[31]);
      end
      3'b001: begin
        s   = {1'b0, a} + {1'b0, ~b} + 33'd1;
        o.r = s[31:0];
        o.c = s[32];
        o.v = (a[31] != b[31]) && (o.r[31] != a[31]);
      end
      3'b010: o.r = a & b;
      3'b011: o.r = a | b;
      3'b101: o.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: o.r = 32'd0;
    endcase
    o.z = (o.r == 32'd0);
    o.n = o.r[31];
    return o;
  endfunction

  alu_out_t alu_o;
  assign alu_o      = alu_ref(alu_a, alu_b, alu_ctrl);
  assign alu_result = alu_o.r;
  assign alu_z      = alu_o.z;
  assign alu_n      = alu_o.n;
  assign alu_v      = alu_o.v;
  assign alu_c      = alu_o.c;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one op in flight, response two cycles after
  // acceptance, round-robin on ties, counter advances on response handshake.
  logic        m_busy  = 1'b0;
  int          m_age   = 0;
  logic        m_owner = 1'b0;
  logic        m_last  = 1'b1;
  int          m_cnt   = 0;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_ctrl;
  alu_out_t    m_exp;
  logic        m_err;
  logic        g0, g1;

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_handshake", {req0_ready, req1_ready, rsp0_valid, rsp1_valid}, 64'd0);
      check("rst_alu_ab", {alu_a, alu_b}, 64'd0);
      check("rst_alu_ctrl", alu_ctrl, 64'd0);
      check("rst_rsp", {rsp_result, rsp_z, rsp_n, rsp_v, rsp_c, rsp_err}, 64'd0);
      check("rst_cnt", op_cnt, 64'd0);
      m_busy = 1'b0;
      m_last = 1'b1;
      m_cnt  = 0;
    end else begin
      check("op_cnt", op_cnt, m_cnt);
      if (!m_busy) begin
        g0 = req0_valid && (!req1_valid || m_last);
        g1 = req1_valid && (!req0_valid || !m_last);
        check("req_ready", {req0_ready, req1_ready}, {g0, g1});
        check("rsp_valid_idle", {rsp0_valid, rsp1_valid}, 64'd0);
        if (g0 || g1) begin
          m_busy  = 1'b1;
          m_age   = 0;
          m_owner = g1;
          m_last  = g1;
          m_a     = g1 ? req1_a : req0_a;
          m_b     = g1 ? req1_b : req0_b;
          m_ctrl  = g1 ? req1_ctrl : req0_ctrl;
          m_exp   = alu_ref(m_a, m_b, m_ctrl);
          m_err   = (m_ctrl == 3'd4) || (m_ctrl == 3'd6) || (m_ctrl == 3'd7);
        end
      end else begin
        m_age++;
        check("req_ready_busy", {req0_ready, req1_ready}, 64'd0);
        check("alu_ab", {alu_a, alu_b}, {m_a, m_b});
        check("alu_ctrl", alu_ctrl, m_ctrl);
        if (m_age < 2) begin
          check("rsp_valid_exec", {rsp0_valid, rsp1_valid}, 64'd0);
        end else begin
          check("rsp_valid", {rsp0_valid, rsp1_valid}, m_owner ? 2'b01 : 2'b10);
          check("rsp_result", rsp_result, m_exp.r);
          check("rsp_flags", {rsp_z, rsp_n, rsp_v, rsp_c, rsp_err},
                {m_exp.z, m_exp.n, m_exp.v, m_exp.c, m_err});
          if (m_owner ? rsp1_ready : rsp0_ready) begin
            m_busy = 1'b0;
            m_cnt  = (m_cnt + 1) % 16;
          end
        end
      end
    end
  end

  // Observation logs used by the directed literal checks.
  int       cyc = 0;
  int       gnt_who[$];
  int       gnt_cyc[$];
  int       rsp_who[$];
  int       rsp_cyc[$];
  alu_out_t rsp_val[$];
  logic     rsp_erq[$];

  task automatic step();
    logic h0, h1;
    @(negedge clk);
    h0 = req0_valid && req0_ready;
    h1 = req1_valid && req1_ready;
    if (h0) begin gnt_who.push_back(0); gnt_cyc.push_back(cyc); end
    if (h1) begin gnt_who.push_back(1); gnt_cyc.push_back(cyc); end
    if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
      rsp_who.push_back(rsp1_valid ? 1 : 0);
      rsp_cyc.push_back(cyc);
      rsp_val.push_back({rsp_result, rsp_z, rsp_n, rsp_v, rsp_c});
      rsp_erq.push_back(rsp_err);
    end
    cyc++;
    @(posedge clk);
    #1;
    if (h0) req0_valid = 1'b0;
    if (h1) req1_valid = 1'b0;
  endtask

  task automatic run_until(input int ng, input int nr);
    int n;
    n = 0;
    while ((gnt_who.size() < ng || rsp_who.size() < nr) && n < 100) begin
      step();
      n++;
    end
    check("progress_timeout", (gnt_who.size() >= ng) && (rsp_who.size() >= nr), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  alu_out_t   pin;
  int         ng, nr, c0;
  logic [2:0] ctab [8];

  initial begin
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_ctrl = '0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_ctrl = '0;
    rsp0_ready = 1; rsp1_ready = 1;
    ctab = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd7, 3'd6};
    #1 rst = 1'b0;

    // Pin the reference ALU with hand-computed values.
    pin = alu_ref(32'd5, 32'd7, 3'b000);
    check("pin_add", {pin.r, pin.z, pin.n}, {32'd12, 1'b0, 1'b0});
    pin = alu_ref(32'd3, 32'd3, 3'b001);
    check("pin_sub_zero", {pin.r, pin.z, pin.c}, {32'd0, 1'b1, 1'b1});
    pin = alu_ref(32'h7fffffff, 32'd1, 3'b000);
    check("pin_add_ovf", {pin.r, pin.v, pin.n}, {32'h80000000, 1'b1, 1'b1});
    pin = alu_ref(32'd1, 32'd2, 3'b101);
    check("pin_slt", pin.r, 64'd1);
    pin = alu_ref(32'd9, 32'd4, 3'b111);
    check("pin_unsup", {pin.r, pin.z}, {32'd0, 1'b1});

    repeat (3) step();
    rst = 1'b1;

    // 1: reset while EXEC aborts the op; then req1 alone is granted at once.
    ng = gnt_who.size(); nr = rsp_who.size();
    req0_a = 32'd1; req0_b = 32'd1; req0_ctrl = 3'b000; req0_valid = 1;
    run_until(ng + 1, 0);
    do_reset();
    repeat (3) step();
    check("abort_no_rsp", rsp_who.size(), nr);
    ng = gnt_who.size(); c0 = cyc;
    req1_a = 32'd10; req1_b = 32'd3; req1_ctrl = 3'b001; req1_valid = 1;
    run_until(ng + 1, nr + 1);
    check("req1_alone_who", gnt_who[ng], 64'd1);
    check("req1_alone_cyc", gnt_cyc[ng], c0);
    check("req1_alone_res", rsp_val[nr].r, 64'd7);

    // 2: req0 5+7, response two cycles after acceptance.
    step();
    ng = gnt_who.size(); nr = rsp_who.size(); c0 = cyc;
    req0_a = 32'd5; req0_b = 32'd7; req0_ctrl = 3'b000; req0_valid = 1;
    run_until(ng + 1, nr + 1);
    check("t2_grant_cyc", gnt_cyc[ng], c0);
    check("t2_latency", rsp_cyc[nr] - gnt_cyc[ng], 64'd2);
    check("t2_res", {rsp_val[nr].r, rsp_val[nr].z, rsp_val[nr].n, rsp_erq[nr]},
          {32'd12, 1'b0, 1'b0, 1'b0});
    step();
    check("t2_op_cnt", op_cnt, 64'd2);

    // 3: tie after reset; req0 first.
    do_reset();
    ng = gnt_who.size(); nr = rsp_who.size();
    req0_a = 32'd3; req0_b = 32'd3; req0_ctrl = 3'b001; req0_valid = 1;
    req1_a = 32'd1; req1_b = 32'd2; req1_ctrl = 3'b101; req1_valid = 1;
    run_until(ng + 2, nr + 2);
    check("t3_order", {gnt_who[ng][0], gnt_who[ng + 1][0]}, 2'b01);
    check("t3_rsp0", {rsp_who[nr][0], rsp_val[nr].r, rsp_val[nr].z}, {1'b0, 32'd0, 1'b1});
    check("t3_rsp1", {rsp_who[nr + 1][0], rsp_val[nr + 1].r}, {1'b1, 32'd1});

    // 4: owner stalls its response; req1 waits, then wins the next IDLE cycle.
    ng = gnt_who.size(); nr = rsp_who.size();
    rsp0_ready = 0;
    req0_a = 32'hF0; req0_b = 32'h3C; req0_ctrl = 3'b010; req0_valid = 1;
    run_until(ng + 1, 0);
    req1_a = 32'd6; req1_b = 32'd6; req1_ctrl = 3'b011; req1_valid = 1;
    repeat (7) step();
    check("t4_no_grant_in_resp", gnt_who.size(), ng + 1);
    check("t4_no_rsp_while_stalled", rsp_who.size(), nr);
    rsp0_ready = 1;
    run_until(ng + 2, nr + 2);
    check("t4_rsp0", rsp_val[nr].r, 64'h30);
    check("t4_req1_next_idle", gnt_cyc[ng + 1] - rsp_cyc[nr], 64'd1);
    check("t4_rsp1", {rsp_who[nr + 1][0], rsp_val[nr + 1].r}, {1'b1, 32'd6});

    // 5: unsupported ctrl flags rsp_err; the next legal op clears it.
    ng = gnt_who.size(); nr = rsp_who.size();
    req1_a = 32'd9; req1_b = 32'd4; req1_ctrl = 3'b111; req1_valid = 1;
    run_until(ng + 1, nr + 1);
    check("t5_err", {rsp_val[nr].r, rsp_val[nr].z, rsp_erq[nr]}, {32'd0, 1'b1, 1'b1});
    req1_a = 32'd2; req1_b = 32'd2; req1_ctrl = 3'b000; req1_valid = 1;
    run_until(ng + 2, nr + 2);
    check("t5_legal", {rsp_val[nr + 1].r, rsp_erq[nr + 1]}, {32'd4, 1'b0});

    // 6: 17 ops under continuous contention; op_cnt wraps to 1, grants alternate.
    do_reset();
    ng = gnt_who.size(); nr = rsp_who.size();
    req0_valid = 1; req1_valid = 1;
    for (int k = 0; k < 200 && gnt_who.size() < ng + 17; k++) begin
      if (!req0_valid) begin
        req0_a = $urandom; req0_b = $urandom; req0_ctrl = ctab[$urandom_range(0, 7)];
        req0_valid = 1;
      end
      if (!req1_valid) begin
        req1_a = $urandom; req1_b = $urandom; req1_ctrl = ctab[$urandom_range(0, 7)];
        req1_valid = 1;
      end
      step();
    end
    req0_valid = 0; req1_valid = 0;
    run_until(ng + 17, nr + 17);
    step();
    check("t6_op_cnt_wrap", op_cnt, 64'd1);
    for (int i = 0; i < 17; i++) begin
      check("t6_alternate", gnt_who[ng + i], i % 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
